// File: rtl/mips_pkg.sv
// Shared word/address widths and the pending-store entry layout used by store_buffer.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:2] addr;
        logic [WORD_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Associative lookup over the pending-store ring: per-entry hit vector restricted to
// live entries, and the index of the youngest hit found by walking back from tail.
module sb_match
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][ADDR_W-3:0] entry_addr,
    input  logic [PTR_W-1:0]             head,
    input  logic [PTR_W-1:0]             tail,
    input  logic [CNT_W-1:0]             count,
    input  logic [ADDR_W-3:0]            lookup_addr,
    output logic [DEPTH-1:0]             hit_vec,
    output logic [PTR_W-1:0]             youngest_idx
);

    always_comb begin
        logic [PTR_W-1:0] offset;
        offset  = '0;
        hit_vec = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            offset     = PTR_W'(j) - head;
            hit_vec[j] = (CNT_W'(offset) < count) && (entry_addr[j] == lookup_addr);
        end
    end

    // Live entries occupy tail-1 down to tail-count, so the first hit walking back is youngest.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        found        = 1'b0;
        idx          = '0;
        youngest_idx = '0;
        for (int unsigned i = 1; i <= DEPTH; i++) begin
            idx = tail - PTR_W'(i);
            if (!found && hit_vec[idx]) begin
                found        = 1'b1;
                youngest_idx = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer between the MEM stage and a single-port data memory.
// Define STORE_BUFFER_FWD_EN to forward pending store data to matching loads instead of stalling.
module store_buffer
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    output logic          dm_we,
    output logic          dm_re,
    input  logic [31:0]   dm_rdata,
    output logic          buf_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    sb_entry_t [DEPTH-1:0]         buf_q, buf_d;
    logic [PTR_W-1:0]              head_q, head_d;
    logic [PTR_W-1:0]              tail_q, tail_d;
    logic [CNT_W-1:0]              count_q, count_d;

    logic [DEPTH-1:0][ADDR_W-3:0]  entry_addr;
    logic [ADDR_W-3:0]             req_word;
    logic [DEPTH-1:0]              hit_vec;
    logic [PTR_W-1:0]              youngest_idx;
    logic                          any_hit;
    logic                          full;
    logic                          load_blocked;
    logic                          load_owns;
    logic                          drain;
    logic                          enq;
    logic                          unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];
    assign req_word         = cpu_addr[AW-1:2];

    always_comb begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
            entry_addr[j] = buf_q[j].addr;
        end
    end

    sb_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .entry_addr   (entry_addr),
        .head         (head_q),
        .tail         (tail_q),
        .count        (count_q),
        .lookup_addr  (req_word),
        .hit_vec      (hit_vec),
        .youngest_idx (youngest_idx)
    );

    // A load to a pending word either forwards or yields the port to the drain.
    always_comb begin
        any_hit      = |hit_vec;
        full         = (count_q == FULL_CNT);
        load_blocked = cpu_re && any_hit && !FWD_EN;
        load_owns    = cpu_re && !load_blocked;
        drain        = !rst && !load_owns && (count_q != '0);
        enq          = !rst && cpu_we && !cpu_re && !full;
    end

    always_comb begin
        buf_d   = buf_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            buf_d[tail_q].addr = req_word;
            buf_d[tail_q].data = cpu_wdata;
            tail_d             = tail_q + PTR_W'(1);
        end
        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({enq, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_we     = 1'b0;
        dm_re     = 1'b0;
        if (!rst) begin
            cpu_stall = (cpu_re && cpu_we) || load_blocked || (cpu_we && !cpu_re && full);
            if (load_owns) begin
                dm_re     = 1'b1;
                dm_addr   = {cpu_addr[AW-1:2], 2'b00};
                cpu_rdata = (FWD_EN && any_hit) ? buf_q[youngest_idx].data : dm_rdata;
            end else if (drain) begin
                dm_we    = 1'b1;
                dm_addr  = {buf_q[head_q].addr, 2'b00};
                dm_wdata = buf_q[head_q].data;
            end
        end
        buf_empty = rst || (count_q == '0);
    end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized scoreboard bench for store_buffer against a queue-based program-order model;
// honours STORE_BUFFER_FWD_EN the same way the design does.
module tb_store_buffer;
    import mips_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic          cpu_we = 1'b0;
    logic          cpu_re = 1'b0;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_we;
    logic          dm_re;
    logic [31:0]   dm_rdata;
    logic          buf_empty;

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_we     (dm_we),
        .dm_re     (dm_re),
        .dm_rdata  (dm_rdata),
        .buf_empty (buf_empty)
    );

    typedef struct {
        logic [29:0] word;
        logic [31:0] data;
    } st_t;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          dm_re;
        bit          dm_we;
        bit          empty;
        logic [29:0] ld_word;
    } ctrl_t;

    st_t         pend[$];
    st_t         exp_wr[$];
    logic [31:0] exp_ld[$];
    ctrl_t       exp_ctrl[$];
    logic [31:0] arch[logic [29:0]];
    logic [31:0] committed[logic [29:0]];
    logic [31:0] dm_mem[logic [29:0]];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] init_val(input logic [29:0] w);
        return {w[15:0], ~w[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] arch_rd(input logic [29:0] w);
        return arch.exists(w) ? arch[w] : init_val(w);
    endfunction

    function automatic logic [31:0] dm_rd(input logic [29:0] w);
        return dm_mem.exists(w) ? dm_mem[w] : init_val(w);
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [29:0] w;
        w = 30'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) w[20] = 1'b1;
        return {w, 2'($urandom_range(0, 3))};
    endfunction

    always @* dm_rdata = dm_re ? dm_rd(dm_addr[31:2]) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides the expected response and pushes it.
    task automatic cycle(input bit r, input bit re, input bit we, input logic [31:0] addr,
                         input logic [31:0] data, output bit stall, output bit ld_done);
        ctrl_t       c;
        st_t         s;
        bit          hit;
        bit          lp;
        bit          accept;
        logic [29:0] w;
        @(posedge clk);
        #1;
        rst       = r;
        cpu_re    = re;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = data;
        w         = addr[31:2];
        c.rst     = r;
        c.empty   = r || (pend.size() == 0);
        c.ld_word = w;
        stall     = 1'b0;
        ld_done   = 1'b0;
        if (r) begin
            c.stall = 1'b0;
            c.dm_re = 1'b0;
            c.dm_we = 1'b0;
            pend.delete();
            arch = committed;
        end else begin
            hit = 1'b0;
            foreach (pend[i]) if (pend[i].word == w) hit = 1'b1;
            lp      = re && (FWD || !hit);
            c.dm_re = lp;
            c.dm_we = !lp && (pend.size() > 0);
            c.stall = (re && we) || (re && !FWD && hit) || (!re && we && pend.size() == DEPTH);
            accept  = we && !re && (pend.size() < DEPTH);
            if (lp) exp_ld.push_back(arch_rd(w));
            if (c.dm_we) begin
                s = pend.pop_front();
                exp_wr.push_back(s);
                committed[s.word] = s.data;
            end
            if (accept) begin
                s.word = w;
                s.data = data;
                pend.push_back(s);
                arch[w] = data;
            end
            stall   = c.stall;
            ld_done = lp;
        end
        exp_ctrl.push_back(c);
    endtask

    // MEM stage behaviour: hold a stalled request; once its load half is serviced retry the store alone.
    task automatic issue(input bit re, input bit we, input logic [31:0] addr, input logic [31:0] data);
        bit st;
        bit ld;
        bit r2;
        int n;
        r2 = re;
        n  = 0;
        do begin
            cycle(1'b0, r2, we, addr, data, st, ld);
            if (ld) r2 = 1'b0;
            n++;
        end while (st && n < 50);
    endtask

    task automatic idle(input int unsigned n);
        bit st;
        bit ld;
        for (int unsigned k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, '0, '0, st, ld);
    endtask

    task automatic do_reset(input bit re, input bit we, input logic [31:0] addr);
        bit st;
        bit ld;
        cycle(1'b1, re, we, addr, 32'hBAD0_BAD0, st, ld);
    endtask

    always @(negedge clk) begin
        ctrl_t c;
        st_t   s;
        if (exp_ctrl.size() != 0) begin
            c = exp_ctrl.pop_front();
            chk("cpu_stall", cpu_stall, c.stall);
            chk("dm_re", dm_re, c.dm_re);
            chk("dm_we", dm_we, c.dm_we);
            chk("buf_empty", buf_empty, c.empty);
            if (!c.dm_re && !c.dm_we) begin
                chk("idle_dm_addr", dm_addr, 0);
                chk("idle_dm_wdata", dm_wdata, 0);
                if (!c.dm_we && (c.rst || !cpu_re)) chk("idle_cpu_rdata", cpu_rdata, 0);
            end
            if (dm_we) begin
                if (exp_wr.size() == 0) begin
                    chk("dm_write_unexpected", dm_addr, 32'hFFFF_FFFF);
                end else begin
                    s = exp_wr.pop_front();
                    chk("dm_write_addr", dm_addr, {s.word, 2'b00});
                    chk("dm_write_data", dm_wdata, s.data);
                end
                dm_mem[dm_addr[31:2]] = dm_wdata;
            end
            if (dm_re) begin
                chk("dm_read_addr", dm_addr, {c.ld_word, 2'b00});
                if (exp_ld.size() == 0) begin
                    chk("load_unexpected", cpu_rdata, 32'hFFFF_FFFF);
                end else begin
                    chk("load_data", cpu_rdata, exp_ld.pop_front());
                end
            end
        end
    end

    initial begin
        int unsigned p;
        int unsigned n;
        do_reset(1'b0, 1'b0, '0);
        do_reset(1'b1, 1'b1, 32'h0000_0010);

        issue(1'b0, 1'b1, 32'h0000_0010, 32'hAAAA_0001);
        idle(2);
        issue(1'b1, 1'b0, 32'h0000_0010, '0);

        issue(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0001);
        issue(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0002);
        issue(1'b1, 1'b0, 32'h0000_0022, '0);
        idle(2);

        issue(1'b1, 1'b1, 32'h0000_0030, 32'h3030_3030);
        issue(1'b1, 1'b0, 32'h0000_0031, '0);
        idle(2);

        for (int unsigned k = 0; k < 5; k++) begin
            issue(1'b0, 1'b1, 32'h0000_0040 + 4 * k, 32'h4000_0000 + k);
            issue(1'b1, 1'b0, 32'h0000_0080, '0);
        end
        idle(2);

        for (int unsigned k = 0; k < 10; k++) begin
            issue(1'b0, 1'b1, 32'h0000_0100 + 4 * (k % 3), 32'h1000_0000 + k);
            idle(1);
        end

        for (int unsigned k = 0; k < 3; k++) issue(1'b0, 1'b1, 32'h0000_0200 + 4 * k, 32'h2000_0000 + k);
        do_reset(1'b1, 1'b1, 32'h0000_0200);
        idle(1);
        for (int unsigned k = 0; k < 3; k++) issue(1'b1, 1'b0, 32'h0000_0200 + 4 * k, '0);

        for (int unsigned k = 0; k < 1500; k++) begin
            p = $urandom_range(0, 99);
            if (p < 2)       do_reset(1'($urandom), 1'($urandom), rnd_addr());
            else if (p < 40) issue(1'b0, 1'b1, rnd_addr(), $urandom);
            else if (p < 70) issue(1'b1, 1'b0, rnd_addr(), '0);
            else if (p < 80) issue(1'b1, 1'b1, rnd_addr(), $urandom);
            else             idle(1);
        end

        n = 0;
        while (pend.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        idle(1);
        @(negedge clk);
        #1;
        chk("pending_writes_left", exp_wr.size(), 0);
        chk("pending_loads_left", exp_ld.size(), 0);
        chk("ctrl_records_left", exp_ctrl.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of pending-store entries; power of two, 2..16.
REQ-002 Parameter: AW, 32, byte-address width.
REQ-003 Port: clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: cpu_addr  in  AW  MEM-stage byte address; bits [1:0] ignored (word access only).
REQ-006 Port: cpu_wdata  in  32  store data.
REQ-007 Port: cpu_we  in  1  store request.
REQ-008 Port: cpu_re  in  1  load request.
REQ-009 Port: cpu_rdata  out  32  load result.
REQ-010 Port: cpu_stall  out  1  MEM stage must hold its request this cycle.
REQ-011 Port: dm_addr  out  AW  data-memory address, word-aligned ([1:0]=0).
REQ-012 Port: dm_wdata  out  32  data-memory write data.
REQ-013 Port: dm_we  out  1  data-memory write enable.
REQ-014 Port: dm_re  out  1  data-memory read enable.
REQ-015 Port: dm_rdata  in  32  data-memory read data, valid in the same cycle dm_re is high.
REQ-016 Port: buf_empty  out  1  no pending stores.

Function
REQ-017 Buffer SHALL be a circular FIFO of DEPTH entries {word address, data}, head/tail pointers wrapping modulo DEPTH, count 0..DEPTH.
REQ-018 Store with cpu_we=1 and count<DEPTH SHALL enqueue at posedge; cpu_stall=0; one-cycle acceptance latency.
REQ-019 Store with count==DEPTH SHALL assert cpu_stall; not enqueued even if a drain pops that cycle; accepted next cycle.
REQ-020 Load (cpu_re=1, not stalled) SHALL own the DM port: dm_re=1, dm_addr={cpu_addr[AW-1:2],2'b00}, dm_we=0.
REQ-021 Drain: in any cycle where the DM port is not owned by a load and count>0, dm_we=1 with head entry; head pops at posedge.
REQ-022 Simultaneous enqueue and drain SHALL leave count unchanged; pointers both advance.
REQ-023 cpu_re and cpu_we both high SHALL be treated as load only; cpu_stall=1 so the store is retried.
REQ-024 Loads SHALL be combinational to cpu_rdata in the request cycle; idle cycles drive cpu_rdata=0, dm_* =0.
REQ-025 Address match SHALL compare bits [AW-1:2] only.
REQ-026 buf_empty SHALL equal (count==0) from registered state.
REQ-027 Stores SHALL reach DM in program order; each store written exactly once.

Reset
REQ-028 rst at posedge SHALL set count=0, head=tail=0, discarding pending stores, including mid-drain.
REQ-029 During/after reset cycle outputs SHALL be: cpu_stall=0, cpu_rdata=0, dm_we=0, dm_re=0, dm_addr=0, dm_wdata=0, buf_empty=1.
REQ-030 Requests during the rst cycle SHALL be ignored.

Configuration
REQ-031 Macro STORE_BUFFER_FWD_EN defined: load matching any pending entry returns youngest matching entry's data, no stall; dm_re still asserted.
REQ-032 Macro undefined: load matching any pending entry asserts cpu_stall, dm_re=0, and drain proceeds that cycle; load completes once no entry matches.

Structure
REQ-033 Shared package mips_pkg SHALL hold word width (32), address width, and the entry struct typedef {addr[AW-1:2], data[31:0]}.
REQ-034 One sub-module sb_match SHALL compute per-entry hit vector and youngest-hit index relative to tail (present in both configurations).

Verification
REQ-035 Store 0x10<-0xAAAA0001, then idle 1 cycle -> dm_we=1, dm_addr=0x10, dm_wdata=0xAAAA0001; buf_empty=1 after.
REQ-036 With DEPTH=4, 5 consecutive stores under continuous loads to 0x80 -> 5th store sees cpu_stall=1 until first non-load cycle; DM writes in order.
REQ-037 Store 0x20<-1, store 0x20<-2, load 0x22 next cycle -> with FWD_EN cpu_rdata=2, no stall; without, stall until both drained, then 2 from DM.
REQ-038 Pointer wrap: 10 store/drain pairs with DEPTH=4 -> all 10 writes appear at DM in order, count never exceeds 4.
REQ-039 rst with 3 pending stores -> no further dm_we, buf_empty=1 next cycle, later load returns DM contents.
REQ-040 cpu_re=cpu_we=1 to 0x30 -> load serviced, cpu_stall=1, store enqueued once after release.
